// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit accumulator CPU: opcodes, condition codes,
// FSM states, serial frame length and the branch-condition helper.
package cpu_pkg;

    localparam logic [3:0] OP_LOAD  = 4'b0000;
    localparam logic [3:0] OP_AND   = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0100;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_JUMP  = 4'b1000;
    localparam logic [3:0] OP_JCC   = 4'b1001;
    localparam logic [3:0] OP_INPUT = 4'b1010;
    localparam logic [3:0] OP_OUT   = 4'b1110;

    localparam logic [1:0] CC_Z  = 2'b00;
    localparam logic [1:0] CC_NZ = 2'b01;
    localparam logic [1:0] CC_C  = 2'b10;
    localparam logic [1:0] CC_NC = 2'b11;

    typedef enum logic {
        FETCH   = 1'b0,
        EXECUTE = 1'b1
    } state_t;

    // Start bit + 8 data bits + stop bit.
    localparam int FRAME_LEN = 10;

    function automatic logic cond_met(input logic [1:0] cc, input logic z, input logic c);
        case (cc)
            CC_Z:    return z;
            CC_NZ:   return !z;
            CC_C:    return c;
            default: return !c;
        endcase
    endfunction

endpackage

// File: rtl/ram_256x16.sv
// Unified program/data memory: 256 x 16, combinational read, synchronous write.
// Deliberately not reset so that preloaded programs survive CLR.
module ram_256x16 (
    input  logic        clk_i,
    input  logic        we_i,
    input  logic [7:0]  addr_i,
    input  logic [15:0] wdata_i,
    output logic [15:0] rdata_o
);

    logic [15:0] memory [0:255];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            memory[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = memory[addr_i];

endmodule

// File: rtl/system_toplevel.sv
// Accumulator CPU system: two-state fetch/execute core, shared RAM and a
// one-wire LSB-first serial transmitter fed by OUTPUT instructions.
module system_toplevel
    import cpu_pkg::*;
(
    input  logic CLK,
    input  logic CLR,
    output logic SERIAL_OUT
);

    state_t      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [7:0]  acc_q, acc_d;
    logic        z_q, z_d;
    logic        c_q, c_d;
    logic [15:0] ir_q, ir_d;
    logic [8:0]  tx_sr_q, tx_sr_d;
    logic [3:0]  tx_cnt_q, tx_cnt_d;
    logic        ser_q, ser_d;

    logic [15:0] ram_rdata;
    logic [7:0]  ram_addr;
    logic        ram_we;
    logic [3:0]  opcode;
    logic [7:0]  operand;
    logic [8:0]  sum_w;
    logic [7:0]  diff_w;
    logic        unused_ir_bits;

    assign opcode         = ir_q[15:12];
    assign operand        = ir_q[7:0];
    assign unused_ir_bits = ^ir_q[9:8];
    assign sum_w          = {1'b0, acc_q} + {1'b0, operand};
    assign diff_w         = acc_q - operand;

    // Fetch uses the PC; execute uses the operand as data address.
    assign ram_addr = (state_q == FETCH) ? pc_q : operand;
    assign ram_we   = (state_q == EXECUTE) && (opcode == OP_OUT) && !CLR;

    ram_256x16 RAM_1 (
        .clk_i   (CLK),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i ({8'h00, acc_q}),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        acc_d    = acc_q;
        z_d      = z_q;
        c_d      = c_q;
        ir_d     = ir_q;
        tx_sr_d  = tx_sr_q;
        tx_cnt_d = tx_cnt_q;
        ser_d    = 1'b1;

        // Shift register already holds data bits and the stop bit; refill with idle ones.
        if (tx_cnt_q != 4'd0) begin
            ser_d    = tx_sr_q[0];
            tx_sr_d  = {1'b1, tx_sr_q[8:1]};
            tx_cnt_d = tx_cnt_q - 4'd1;
        end

        case (state_q)
            FETCH: begin
                ir_d    = ram_rdata;
                pc_d    = pc_q + 8'd1;
                state_d = EXECUTE;
            end
            default: begin
                state_d = FETCH;
                case (opcode)
                    OP_LOAD: acc_d = operand;
                    OP_AND: begin
                        acc_d = acc_q & operand;
                        z_d   = ((acc_q & operand) == 8'h00);
                        c_d   = 1'b0;
                    end
                    OP_ADD: begin
                        acc_d = sum_w[7:0];
                        z_d   = (sum_w[7:0] == 8'h00);
                        c_d   = sum_w[8];
                    end
                    OP_SUB: begin
                        acc_d = diff_w;
                        z_d   = (diff_w == 8'h00);
                        c_d   = (operand > acc_q);
                    end
                    OP_JUMP: pc_d = operand;
                    OP_JCC: begin
                        if (cond_met(ir_q[11:10], z_q, c_q)) begin
                            pc_d = operand;
                        end
                    end
                    OP_INPUT: acc_d = ram_rdata[7:0];
                    OP_OUT: begin
                        // A new frame always wins over one still in flight.
                        ser_d    = 1'b0;
                        tx_sr_d  = {1'b1, acc_q};
                        tx_cnt_d = 4'(FRAME_LEN - 1);
                    end
                    default: ;
                endcase
            end
        endcase
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_q  <= FETCH;
            pc_q     <= 8'h00;
            acc_q    <= 8'h00;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            ir_q     <= 16'h0000;
            tx_sr_q  <= 9'h1FF;
            tx_cnt_q <= 4'd0;
            ser_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            acc_q    <= acc_d;
            z_q      <= z_d;
            c_q      <= c_d;
            ir_q     <= ir_d;
            tx_sr_q  <= tx_sr_d;
            tx_cnt_q <= tx_cnt_d;
            ser_q    <= ser_d;
        end
    end

    assign SERIAL_OUT = ser_q;

endmodule

// File: tb/tb_system_toplevel.sv
// Bench for system_toplevel: an instruction-level model of the CPU and its
// serial frames runs in lock step with the DUT over directed and random programs.
module tb_system_toplevel;

    logic CLK = 1'b0;
    logic CLR = 1'b0;
    logic SERIAL_OUT;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] m_mem [256];
    logic [7:0]  m_pc, m_acc;
    logic        m_z, m_c;
    logic [15:0] m_ir;
    logic [9:0]  m_frame;
    int          m_pos = 10;
    bit          ser_log[$];

    system_toplevel dut (
        .CLK        (CLK),
        .CLR        (CLR),
        .SERIAL_OUT (SERIAL_OUT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        ser_log.push_back(SERIAL_OUT);
    endtask

    function automatic logic exp_ser();
        return (m_pos < 10) ? m_frame[m_pos] : 1'b1;
    endfunction

    function automatic logic is_trap(input logic [7:0] p);
        return (p == 8'h0E) || (p == 8'h11) || (p == 8'h15) || (p == 8'h18);
    endfunction

    task automatic put(input int a, input logic [15:0] w);
        dut.RAM_1.memory[a] = w;
        m_mem[a] = w;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) put(i, 16'h0000);
    endtask

    task automatic begin_reset();
        CLR = 1'b1;
        m_pc = 8'h00; m_acc = 8'h00; m_z = 1'b0; m_c = 1'b0;
        m_ir = 16'h0000; m_pos = 10;
    endtask

    task automatic finish_reset(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk("rst_pc",  32'(dut.pc_q),  32'h00);
            chk("rst_acc", 32'(dut.acc_q), 32'h00);
            chk("rst_zc",  32'({dut.z_q, dut.c_q}), 32'h0);
            chk("rst_ser", 32'(SERIAL_OUT), 32'h1);
        end
        CLR = 1'b0;
    endtask

    task automatic do_fetch();
        logic [15:0] w;
        w = m_mem[m_pc];
        tick();
        m_ir = w;
        m_pc = m_pc + 8'd1;
        if (m_pos < 10) m_pos++;
        chk("fetch_pc",  32'(dut.pc_q), 32'(m_pc));
        chk("fetch_ir",  32'(dut.ir_q), 32'(m_ir));
        chk("fetch_ser", 32'(SERIAL_OUT), 32'(exp_ser()));
    endtask

    task automatic do_exec();
        logic [7:0] imm;
        logic [8:0] s;
        logic       taken;
        imm = m_ir[7:0];
        if (m_pos < 10) m_pos++;
        case (m_ir[15:12])
            4'h0: m_acc = imm;
            4'h1: begin m_acc = m_acc & imm; m_z = (m_acc == 8'h00); m_c = 1'b0; end
            4'h4: begin
                s = {1'b0, m_acc} + {1'b0, imm};
                m_acc = s[7:0]; m_c = s[8]; m_z = (m_acc == 8'h00);
            end
            4'h6: begin m_c = (imm > m_acc); m_acc = m_acc - imm; m_z = (m_acc == 8'h00); end
            4'h8: m_pc = imm;
            4'h9: begin
                case (m_ir[11:10])
                    2'b00: taken = m_z;
                    2'b01: taken = !m_z;
                    2'b10: taken = m_c;
                    default: taken = !m_c;
                endcase
                if (taken) m_pc = imm;
            end
            4'hA: m_acc = m_mem[imm][7:0];
            4'hE: begin
                m_mem[imm] = {8'h00, m_acc};
                m_frame = {1'b1, m_acc, 1'b0};
                m_pos = 0;
            end
            default: ;
        endcase
        tick();
        chk("exec_pc",  32'(dut.pc_q),  32'(m_pc));
        chk("exec_acc", 32'(dut.acc_q), 32'(m_acc));
        chk("exec_z",   32'(dut.z_q),   32'(m_z));
        chk("exec_c",   32'(dut.c_q),   32'(m_c));
        chk("exec_ser", 32'(SERIAL_OUT), 32'(exp_ser()));
    endtask

    task automatic run_instr();
        do_fetch();
        do_exec();
    endtask

    task automatic chk_frame(input string tag, input logic [10:0] exp_bits);
        for (int i = 0; i < 11; i++) begin
            if (i < ser_log.size()) chk(tag, 32'(ser_log[i]), 32'(exp_bits[i]));
            else chk({tag, "_short"}, 32'(ser_log.size()), 32'(11));
        end
    endtask

    initial begin
        logic [3:0]  ops [8];
        logic [31:0] r;

        // Overflow program
        begin_reset();
        clear_mem();
        put(0, 16'hA006); put(1, 16'h400A); put(2, 16'h9C04); put(3, 16'h00FF);
        put(4, 16'hE007); put(5, 16'h8000); put(6, 16'h00FA); put(7, 16'h0000);
        finish_reset(5);
        run_instr();
        chk("ovf_input_acc", 32'(dut.acc_q), 32'hFA);
        run_instr();
        chk("ovf_add_acc", 32'(dut.acc_q), 32'h04);
        chk("ovf_add_c", 32'(dut.c_q), 32'h1);
        chk("ovf_add_z", 32'(dut.z_q), 32'h0);
        run_instr();
        chk("ovf_jnc_pc", 32'(dut.pc_q), 32'h03);
        run_instr();
        chk("ovf_load_acc", 32'(dut.acc_q), 32'hFF);
        do_fetch();
        ser_log.delete();
        do_exec();
        chk("ovf_ram7", 32'(dut.RAM_1.memory[7]), 32'h00FF);
        for (int i = 0; i < 5; i++) run_instr();
        chk_frame("ovf_frame", 11'b111_1111_1110);

        // Full instruction-set program with trap addresses
        begin_reset();
        clear_mem();
        put(8'h00, 16'h0001); put(8'h01, 16'h40FF); put(8'h02, 16'h00AA); put(8'h03, 16'h100F);
        put(8'h04, 16'h0000); put(8'h05, 16'h6001); put(8'h06, 16'hE0F0); put(8'h07, 16'h0000);
        put(8'h08, 16'hA0F0); put(8'h09, 16'h4001); put(8'h0A, 16'hF000); put(8'h0B, 16'hF000);
        put(8'h0C, 16'hF000); put(8'h0D, 16'h900F); put(8'h0E, 16'h800E); put(8'h0F, 16'h4001);
        put(8'h10, 16'h9412); put(8'h11, 16'h8011); put(8'h12, 16'h00FF); put(8'h13, 16'h4001);
        put(8'h14, 16'h9816); put(8'h15, 16'h8015); put(8'h16, 16'h6000); put(8'h17, 16'h9C19);
        put(8'h18, 16'h8018); put(8'h19, 16'h8000);
        finish_reset(5);
        for (int i = 0; i < 22; i++) begin
            run_instr();
            chk("isa_no_trap", 32'(is_trap(dut.pc_q)), 32'h0);
            case (i)
                1: chk("flag_add_wrap", 32'({dut.acc_q, dut.z_q, dut.c_q}), 32'({8'h00, 1'b1, 1'b1}));
                2: chk("flag_load_keep", 32'({dut.acc_q, dut.z_q, dut.c_q}), 32'({8'hAA, 1'b1, 1'b1}));
                3: chk("flag_and", 32'({dut.acc_q, dut.z_q, dut.c_q}), 32'({8'h0A, 1'b0, 1'b0}));
                5: chk("flag_sub_borrow", 32'({dut.acc_q, dut.z_q, dut.c_q}), 32'({8'hFF, 1'b0, 1'b1}));
                7: chk("flag_load_keep2", 32'({dut.acc_q, dut.z_q, dut.c_q}), 32'({8'h00, 1'b0, 1'b1}));
                default: ;
            endcase
        end
        chk("isa_loop_pc", 32'(dut.pc_q), 32'h00);
        chk("isa_ramf0", 32'(dut.RAM_1.memory[8'hF0]), 32'h00FF);

        // Back-to-back OUTPUT: first frame aborted by the second
        begin_reset();
        clear_mem();
        put(0, 16'h0055); put(1, 16'hE080); put(2, 16'h000F); put(3, 16'hE081); put(4, 16'h8004);
        finish_reset(3);
        for (int i = 0; i < 3; i++) run_instr();
        do_fetch();
        ser_log.delete();
        do_exec();
        for (int i = 0; i < 5; i++) run_instr();
        chk_frame("b2b_frame", 11'b110_0001_1110);

        // Reset asserted during EXECUTE of an OUTPUT while a frame is in flight
        begin_reset();
        clear_mem();
        put(0, 16'h0000); put(1, 16'hE091); put(2, 16'hE090);
        put(8'h90, 16'h1234); put(8'h91, 16'hBEEF);
        finish_reset(2);
        run_instr();
        run_instr();
        do_fetch();
        chk("mid_ser_busy", 32'(SERIAL_OUT), 32'h0);
        #2;
        begin_reset();
        #1;
        chk("mid_ser_async", 32'(SERIAL_OUT), 32'h1);
        chk("mid_pc_async", 32'(dut.pc_q), 32'h00);
        tick();
        chk("mid_ram_kept", 32'(dut.RAM_1.memory[8'h90]), 32'h1234);
        chk("mid_ram_prev", 32'(dut.RAM_1.memory[8'h91]), 32'h0000);
        finish_reset(2);
        for (int i = 0; i < 3; i++) run_instr();

        // Random programs against the model
        ops = '{4'h0, 4'h1, 4'h4, 4'h6, 4'h8, 4'h9, 4'hA, 4'hE};
        for (int pass = 0; pass < 3; pass++) begin
            begin_reset();
            for (int i = 0; i < 256; i++) begin
                r = $urandom();
                if (r[31:29] == 3'b000) put(i, r[15:0]);
                else put(i, {ops[r[28:26]], r[11:0]});
            end
            finish_reset(2);
            for (int i = 0; i < 400; i++) run_instr();
            for (int i = 0; i < 256; i++) begin
                chk($sformatf("rand_ram_%0h", i), 32'(dut.RAM_1.memory[i]), 32'(m_mem[i]));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
